// File: rtl/seg_scan_display.sv
// Time-multiplexed 7-segment (+DP) display scanner with per-slot PWM brightness,
// per-digit blink and a frame-synchronous double-buffered load interface.
module seg_scan_display #(
  parameter int NUM_DIGITS   = 4,
  parameter int SCAN_DIV     = 262144,
  parameter int BRIGHT_BITS  = 4,
  parameter int BLINK_FRAMES = 64
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [8*NUM_DIGITS-1:0] seg_in,
  input  logic                    load,
  output logic                    ready,
  input  logic [BRIGHT_BITS-1:0]  brightness,
  input  logic [NUM_DIGITS-1:0]   blink_mask,
  output logic [NUM_DIGITS-1:0]   an,
  output logic [7:0]              seg,
  output logic                    frame_start
);

  localparam int CNT_W = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
  localparam int DIG_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int FR_W  = $clog2(2 * BLINK_FRAMES);
  localparam int CMP_W = CNT_W + BRIGHT_BITS;
  localparam int STEP  = SCAN_DIV >> BRIGHT_BITS;

  logic [CNT_W-1:0]        slot_cnt;
  logic [DIG_W-1:0]        digit_idx;
  logic [FR_W-1:0]         frame_cnt;
  logic [8*NUM_DIGITS-1:0] disp_reg;
  logic [8*NUM_DIGITS-1:0] pend_reg;

  logic                    slot_wrap;
  logic                    digit_last;
  logic                    boundary;
  logic [CMP_W-1:0]        thresh;
  logic                    in_window;
  logic                    blink_off;
  logic                    lit;
  logic [NUM_DIGITS-1:0]   an_next;
  logic [7:0]              seg_next;

  assign slot_wrap   = (slot_cnt == CNT_W'(SCAN_DIV - 1));
  assign digit_last  = (digit_idx == DIG_W'(NUM_DIGITS - 1));
  assign boundary    = slot_wrap && digit_last;
  assign frame_start = boundary;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      slot_cnt  <= '0;
      digit_idx <= '0;
    end else if (slot_wrap) begin
      slot_cnt  <= '0;
      digit_idx <= digit_last ? '0 : digit_idx + 1'b1;
    end else begin
      slot_cnt  <= slot_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frame_cnt <= '0;
    end else if (boundary) begin
      frame_cnt <= (frame_cnt == FR_W'(2 * BLINK_FRAMES - 1)) ? '0 : frame_cnt + 1'b1;
    end
  end

  // Display register only changes on a frame boundary, so a frame is never torn.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      disp_reg <= '1;
      pend_reg <= '1;
      ready    <= 1'b1;
    end else if (boundary && !ready) begin
      disp_reg <= pend_reg;
      ready    <= 1'b1;
    end else if (load && ready) begin
      if (boundary) begin
        disp_reg <= seg_in;
      end else begin
        pend_reg <= seg_in;
        ready    <= 1'b0;
      end
    end
  end

  always_comb begin
    thresh    = CMP_W'(brightness) * CMP_W'(STEP);
    in_window = (&brightness) || ({{BRIGHT_BITS{1'b0}}, slot_cnt} < thresh);
    blink_off = (frame_cnt >= FR_W'(BLINK_FRAMES));
    lit       = (slot_cnt != '0) && (brightness != '0) && in_window &&
                !(blink_off && blink_mask[digit_idx]);
    an_next   = '1;
    seg_next  = 8'hFF;
    if (lit) begin
      an_next[digit_idx] = 1'b0;
      seg_next           = disp_reg[{digit_idx, 3'b000} +: 8];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      an  <= '1;
      seg <= 8'hFF;
    end else begin
      an  <= an_next;
      seg <= seg_next;
    end
  end

endmodule

// File: tb/tb_seg_scan_display.sv
// Scoreboard bench for seg_scan_display: a cycle-count reference model pushes the
// expected outputs for every clock, which are popped and compared after the edge.
module tb_seg_scan_display;

  localparam int ND = 4;
  localparam int SD = 16;
  localparam int BB = 2;
  localparam int BF = 2;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic [31:0]   seg_in = '1;
  logic          load = 1'b0;
  logic          ready;
  logic [BB-1:0] brightness = 2'd3;
  logic [ND-1:0] blink_mask = '0;
  logic [ND-1:0] an;
  logic [7:0]    seg;
  logic          frame_start;

  typedef struct packed {
    logic [3:0] an;
    logic [7:0] seg;
    logic       fs;
    logic       rdy;
  } exp_t;

  exp_t        sb_q[$];
  int          cnt;
  logic [31:0] disp_m;
  logic [31:0] pend_m;
  logic        pend_v;
  int          vec_count = 0;
  int          miscompares = 0;

  seg_scan_display #(
    .NUM_DIGITS(ND), .SCAN_DIV(SD), .BRIGHT_BITS(BB), .BLINK_FRAMES(BF)
  ) dut (
    .clk(clk), .rst_n(rst_n), .seg_in(seg_in), .load(load), .ready(ready),
    .brightness(brightness), .blink_mask(blink_mask), .an(an), .seg(seg),
    .frame_start(frame_start)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    vec_count++;
    if (observed !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s (cnt=%0d): got %0h, expected %0h", tag, cnt, observed, expected);
    end
  endtask

  function automatic void model_reset();
    cnt    = 0;
    disp_m = '1;
    pend_m = '1;
    pend_v = 1'b0;
    sb_q.delete();
  endfunction

  // One clock: called just after a falling edge, returns at the next falling edge.
  task automatic applyStimulus(input logic ld, input logic [31:0] data);
    int   slot, dig, frm;
    logic bnd, lit;
    exp_t e, got;
    load   = ld;
    seg_in = data;
    slot = cnt % SD;
    dig  = (cnt / SD) % ND;
    frm  = (cnt / (SD * ND)) % (2 * BF);
    bnd  = (slot == SD - 1) && (dig == ND - 1);
    lit  = (slot != 0) && (brightness != 0) &&
           ((brightness == 2'd3) || (slot < int'(brightness) * (SD / 4))) &&
           !((frm >= BF) && blink_mask[dig]);
    e.an  = lit ? ~(4'b0001 << dig) : 4'hF;
    e.seg = lit ? disp_m[dig*8 +: 8] : 8'hFF;
    if (bnd && pend_v) begin
      disp_m = pend_m;
      pend_v = 1'b0;
    end else if (ld && !pend_v) begin
      if (bnd) disp_m = data;
      else begin
        pend_m = data;
        pend_v = 1'b1;
      end
    end
    cnt++;
    e.fs  = ((cnt % SD) == SD - 1) && (((cnt / SD) % ND) == ND - 1);
    e.rdy = !pend_v;
    sb_q.push_back(e);
    @(posedge clk);
    #1;
    got = sb_q.pop_front();
    checkOutput("an", {28'b0, an}, {28'b0, got.an});
    checkOutput("seg", {24'b0, seg}, {24'b0, got.seg});
    checkOutput("frame_start", {31'b0, frame_start}, {31'b0, got.fs});
    checkOutput("ready", {31'b0, ready}, {31'b0, got.rdy});
    load = 1'b0;
    @(negedge clk);
  endtask

  task automatic run_cycles(input int n);
    for (int i = 0; i < n; i++) applyStimulus(1'b0, 32'hFFFF_FFFF);
  endtask

  task automatic run_until(input int phase);
    for (int i = 0; i < SD * ND; i++) begin
      if ((cnt % (SD * ND)) == phase) break;
      applyStimulus(1'b0, 32'hFFFF_FFFF);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    checkOutput({tag, "_an"}, {28'b0, an}, 32'h0000_000F);
    checkOutput({tag, "_seg"}, {24'b0, seg}, 32'h0000_00FF);
    checkOutput({tag, "_fs"}, {31'b0, frame_start}, 32'h0);
    checkOutput({tag, "_ready"}, {31'b0, ready}, 32'h1);
  endtask

  initial begin
    model_reset();
    #1 rst_n = 1'b0;
    #2 check_reset_outputs("por");
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();

    // Blank display for a frame, then direct load on the boundary cycle.
    brightness = 2'd3;
    blink_mask = 4'b0000;
    run_until(SD * ND - 1);
    applyStimulus(1'b1, 32'h8899_A4C0);
    run_cycles(2 * SD * ND);

    brightness = 2'd1;
    run_cycles(SD * ND);
    brightness = 2'd0;
    run_cycles(SD * ND);
    brightness = 2'd2;
    run_cycles(SD * ND);

    // Mid-frame load, then a second load while busy that must be ignored.
    brightness = 2'd3;
    run_until(20);
    applyStimulus(1'b1, 32'h92F9_A4B0);
    run_cycles(4);
    applyStimulus(1'b1, 32'h0000_0000);
    run_cycles(2 * SD * ND);

    blink_mask = 4'b0100;
    run_cycles(4 * SD * ND);
    blink_mask = 4'b0000;

    // Asynchronous reset mid-slot with a load pending.
    run_until(10);
    applyStimulus(1'b1, 32'hC0F9_A4B0);
    run_cycles(3);
    #2 rst_n = 1'b0;
    #1 check_reset_outputs("async");
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    run_cycles(SD * ND);
    run_until(30);
    applyStimulus(1'b1, 32'h8088_F9C0);
    run_cycles(2 * SD * ND);

    $display("== %0d vectors applied, %0d miscompares ==", vec_count, miscompares);
    $finish;
  end

endmodule

// File: doc/seg_scan_display.md
SEG_SCAN_DISPLAY -- requirements
Module: seg_scan_display

Interface
REQ-001 Parameter NUM_DIGITS, default 4, number of multiplexed digits, legal 1..8.
REQ-002 Parameter SCAN_DIV, default 262144, clock cycles per digit slot, legal >= 2^BRIGHT_BITS and a multiple of 2^BRIGHT_BITS.
REQ-003 Parameter BRIGHT_BITS, default 4, brightness control width.
REQ-004 Parameter BLINK_FRAMES, default 64, frames per blink half-period, legal >= 1.
REQ-005 clk  input  1  system clock; all state changes on rising edge.
REQ-006 rst_n  input  1  reset, asynchronous, active-low.
REQ-007 seg_in  input  8*NUM_DIGITS  per-digit segment codes, digit i at [8i+7:8i], active-low, bit 7 = DP.
REQ-008 load  input  1  request to capture seg_in.
REQ-009 ready  output  1  high when a load will be accepted.
REQ-010 brightness  input  BRIGHT_BITS  per-slot on-time; sampled every cycle.
REQ-011 blink_mask  input  NUM_DIGITS  bit i set = digit i blinks.
REQ-012 an  output  NUM_DIGITS  digit enables, active-low, registered.
REQ-013 seg  output  8  segment drive, active-low, registered.
REQ-014 frame_start  output  1  one-cycle pulse at each frame boundary.

Function
REQ-015 slot_cnt SHALL count 0..SCAN_DIV-1 and wrap to 0; on wrap, digit index SHALL advance by 1, wrapping NUM_DIGITS-1 -> 0.
REQ-016 Frame boundary = cycle where slot_cnt wraps while digit index = NUM_DIGITS-1; frame_start SHALL be high for exactly that cycle.
REQ-017 Load handshake: load && ready SHALL capture seg_in into a pending register and drive ready low from the next cycle.
REQ-018 load while ready low SHALL be ignored; pending data SHALL be unchanged.
REQ-019 At a frame boundary with a load pending, the pending register SHALL copy into the display register and ready SHALL return high the next cycle; display data never changes mid-frame.
REQ-020 load && ready in a frame-boundary cycle SHALL write seg_in directly to the display register; ready stays high.
REQ-021 Step = SCAN_DIV >> BRIGHT_BITS; a digit is lit while slot_cnt < brightness*step, except brightness all-ones SHALL light the full slot.
REQ-022 brightness = 0 SHALL blank every digit.
REQ-023 slot_cnt = 0 SHALL always be blanked (anti-ghosting dead cycle), overriding REQ-021.
REQ-024 Frame counter SHALL count frames modulo 2*BLINK_FRAMES; blink phase is off when count >= BLINK_FRAMES.
REQ-025 During blink-off phase, digits with blink_mask bit set SHALL be blanked; other digits unaffected.
REQ-026 Lit digit i: an = ~(1<<i), seg = display register digit i; blanked: an all ones, seg = 8'hFF.
REQ-027 an/seg SHALL lag the counter state driving them by exactly one cycle; at most one an bit low at any time.

Reset
REQ-028 rst_n low SHALL immediately force an all ones, seg 8'hFF, frame_start 0, ready 1.
REQ-029 Reset SHALL clear slot_cnt, digit index and frame counter to 0, set display and pending registers to all ones, and drop any pending load.
REQ-030 After rst_n rises, the first slot SHALL be digit 0 with slot_cnt starting at 0.

Verification (bench: NUM_DIGITS=4, SCAN_DIV=16, BRIGHT_BITS=2, BLINK_FRAMES=2)
REQ-031 brightness=3, seg_in=32'h8899A4C0 loaded at boundary -> an cycles 1110,1101,1011,0111, every slot: one blank cycle, then 15 cycles seg = C0,A4,99,88 respectively.
REQ-032 brightness=1 -> each slot lit only at slot_cnt 1..3 (3 cycles), blank for 13; brightness=0 -> an stays 1111.
REQ-033 load mid-frame with new data -> ready low next cycle, old data shown until frame_start, new data from digit 0 of next frame; second load while ready low ignored.
REQ-034 blink_mask=4'b0100 -> digit 2 lit in frames 0,1, blanked in frames 2,3, repeating; digits 0,1,3 always lit.
REQ-035 rst_n pulsed low mid-slot with load pending -> an=1111, seg=FF asynchronously; after release ready=1, display blank until next load, scan restarts at digit 0.
REQ-036 load && ready on frame_start cycle -> new data visible in the very next digit-0 slot, ready never drops.
